// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu
// RV32I-subset core that spends separate cycles on fetch, decode, execute,
// memory and writeback. Instructions and data share one memory port with a
// req/ack handshake, so any memory latency is tolerated.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   mem_req/mem_we        request and write strobe (held until mem_ack)
//   mem_addr/mem_wdata    word address and store data
//   mem_rdata/mem_ack     read data and transfer-complete strobe
//   halt/illegal          core stopped / stopped on an unsupported encoding
//   dbg_sel/dbg_out       debug selector and combinational debug value
//   state_out             current FSM state
module multi_cycle_cpu #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halt,
    output logic              illegal,
    input  logic [3:0]        dbg_sel,
    output logic [31:0]       dbg_out,
    output logic [2:0]        state_out
);

    localparam int RIDX_W = $clog2(NREG);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] pc, ir, a, b, alur, mdr, imm, instret;
    logic [31:0] regs [NREG];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm_dec, alu_res;
    logic        is_legal, is_system, rd_ok, taken;
    logic [RIDX_W-1:0] rd_idx;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    // Registers beyond NREG do not exist: reads give 0, writes are dropped.
    // x0 is never written after reset, so reading it always yields 0.
    assign rd_idx = rd[RIDX_W-1:0];
    assign rd_ok  = (rd != 5'd0) && (int'(rd) < NREG);

    // Register file read ports, feeding A/B in DECODE.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (int'(rs1) < NREG) rs1_val = regs[rs1[RIDX_W-1:0]];
        if (int'(rs2) < NREG) rs2_val = regs[rs2[RIDX_W-1:0]];
    end

    // Legality check; ECALL/EBREAK are handled separately so they halt cleanly.
    assign is_system = (opcode == OP_SYSTEM);

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_RTYPE:  is_legal = ((f7 == 7'b0000000) &&
                                   ((f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) ||
                                    (f3 == 3'b100) || (f3 == 3'b010))) ||
                                  ((f7 == 7'b0100000) && (f3 == 3'b000));
            OP_ADDI:   is_legal = (f3 == 3'b000);
            OP_LOAD:   is_legal = (f3 == 3'b010);
            OP_STORE:  is_legal = (f3 == 3'b010);
            OP_BRANCH: is_legal = (f3 == 3'b000) || (f3 == 3'b001);
            OP_JAL:    is_legal = 1'b1;
            default:   is_legal = 1'b0;
        endcase
    end

    // Immediate generation; B and J formats carry an implicit zero LSB.
    always_comb begin
        case (opcode)
            OP_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:    imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:   imm_dec = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // ALU for R-type and ADDI, evaluated in EXEC from the latched operands.
    always_comb begin
        alu_res = a + imm;
        if (opcode == OP_RTYPE) begin
            case (f3)
                3'b000:  alu_res = f7[5] ? (a - b) : (a + b);
                3'b111:  alu_res = a & b;
                3'b110:  alu_res = a | b;
                3'b100:  alu_res = a ^ b;
                3'b010:  alu_res = {31'b0, ($signed(a) < $signed(b))};
                default: alu_res = a + b;
            endcase
        end
    end

    // BEQ takes on equality, BNE (f3[0]=1) on inequality.
    assign taken = (a == b) ^ f3[0];

    // Main FSM: owns every architectural register, including the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alur    <= '0;
            mdr     <= '0;
            imm     <= '0;
            instret <= '0;
            halt    <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a   <= rs1_val;
                    b   <= rs2_val;
                    imm <= imm_dec;
                    if (is_system) begin
                        halt  <= 1'b1;
                        state <= HALT;
                    end else if (!is_legal) begin
                        halt    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= HALT;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: begin
                            alur  <= a + imm;
                            state <= MEM;
                        end
                        OP_BRANCH: begin
                            pc      <= taken ? (pc + imm) : (pc + 32'd4);
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                        OP_JAL: begin
                            if (rd_ok) regs[rd_idx] <= pc + 32'd4;
                            pc      <= pc + imm;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                        default: begin
                            alur  <= alu_res;
                            state <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        if (opcode == OP_STORE) begin
                            pc      <= pc + 32'd4;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    if (rd_ok) regs[rd_idx] <= (opcode == OP_LOAD) ? mdr : alur;
                    pc      <= pc + 32'd4;
                    instret <= instret + 32'd1;
                    state   <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Memory port: request qualified by rst so an abandoned access drops at once.
    // Address and data come from registers that only change on ack, keeping
    // them stable for the whole wait.
    assign mem_req   = !rst && ((state == FETCH) || (state == MEM));
    assign mem_we    = (state == MEM) && (opcode == OP_STORE);
    assign mem_addr  = (state == MEM) ? alur[ADDR_W+1:2] : pc[ADDR_W+1:2];
    assign mem_wdata = b;
    assign state_out = state;

    // Debug mux for the board LEDs / seven-segment display.
    always_comb begin
        case (dbg_sel)
            4'd0:    dbg_out = pc;
            4'd1:    dbg_out = ir;
            4'd2:    dbg_out = a;
            4'd3:    dbg_out = b;
            4'd4:    dbg_out = alur;
            4'd5:    dbg_out = mdr;
            4'd6:    dbg_out = imm;
            4'd7:    dbg_out = instret;
            4'd8:    dbg_out = {29'b0, state};
            4'd9:    dbg_out = {30'b0, illegal, halt};
            default: dbg_out = '0;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu
// Directed bench for multi_cycle_cpu (NREG=16). A small behavioural memory
// answers requests after a programmable number of wait cycles; programs are
// hand-assembled and every expected value is worked out by hand.
module tb_multi_cycle_cpu;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req, mem_we, mem_ack, halt, illegal;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata, dbg_out;
    logic [3:0]        dbg_sel = 4'd0;
    logic [2:0]        state_out;

    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    logic        auto_ack  = 1'b1;
    logic        force_ack = 1'b0;
    int          wait_cnt  = 0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    multi_cycle_cpu #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .NREG(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halt      (halt),
        .illegal   (illegal),
        .dbg_sel   (dbg_sel),
        .dbg_out   (dbg_out),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // Memory model: ack arrives once a request has waited ack_delay cycles.
    assign mem_ack   = force_ack | (auto_ack & mem_req & (wait_cnt >= ack_delay));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkDbg(input string tag, input logic [3:0] sel, input logic [31:0] expected);
        dbg_sel = sel;
        #1;
        checkOutput(tag, dbg_out, expected);
    endtask

    // Hold reset across two edges with the given memory wait count.
    task automatic applyStimulus(input int delay);
        @(negedge clk);
        rst       = 1'b1;
        auto_ack  = 1'b1;
        force_ack = 1'b0;
        ack_delay = delay;
        repeat (2) @(negedge clk);
    endtask

    task automatic releaseReset();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic runTo(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runToHalt(input int limit);
        while (!halt && cyc < limit) runTo(cyc + 1);
    endtask

    task automatic fillMem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
    endtask

    logic              pend;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_we;
    logic [31:0]       hold_wdata;

    initial begin
        // ALU program, zero-wait memory
        fillMem();
        mem[0] = 32'h0050_0093;   // ADDI x1,x0,5
        mem[1] = 32'hFFD0_0113;   // ADDI x2,x0,-3
        mem[2] = 32'h0020_81B3;   // ADD  x3,x1,x2
        mem[3] = 32'h4020_8233;   // SUB  x4,x1,x2
        mem[4] = 32'h0011_22B3;   // SLT  x5,x2,x1
        mem[5] = 32'h0010_0073;   // EBREAK
        applyStimulus(0);
        checkOutput("rst_state", 32'(state_out), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkDbg("rst_pc", 4'd0, 32'h0);
        checkDbg("rst_instret", 4'd7, 32'h0);
        checkDbg("rst_flags", 4'd9, 32'h0);
        releaseReset();
        #1;
        checkOutput("t1_req0", 32'(mem_req), 32'd1);
        checkOutput("t1_addr0", 32'(mem_addr), 32'd0);
        runTo(1);
        checkDbg("t1_ir0", 4'd1, 32'h0050_0093);
        checkOutput("t1_st_dec", 32'(state_out), 32'd1);
        runTo(2);
        checkDbg("t1_imm0", 4'd6, 32'd5);
        runTo(3);
        checkDbg("t1_alur_addi", 4'd4, 32'd5);
        checkOutput("t1_st_wb", 32'(state_out), 32'd4);
        runTo(4);
        checkDbg("t1_pc1", 4'd0, 32'd4);
        checkDbg("t1_instret1", 4'd7, 32'd1);
        runTo(10);
        checkDbg("t1_add_a", 4'd2, 32'd5);
        checkDbg("t1_add_b", 4'd3, 32'hFFFF_FFFD);
        runTo(11);
        checkDbg("t1_add", 4'd4, 32'd2);
        runTo(15);
        checkDbg("t1_sub", 4'd4, 32'd8);
        runTo(18);
        checkDbg("t1_slt_a", 4'd2, 32'hFFFF_FFFD);
        runTo(19);
        checkDbg("t1_slt", 4'd4, 32'd1);
        runTo(20);
        checkDbg("t1_pc5", 4'd0, 32'd20);
        runTo(21);
        checkOutput("t1_halt_early", 32'(halt), 32'd0);
        runTo(22);
        checkOutput("t1_halt", 32'(halt), 32'd1);
        checkOutput("t1_illegal", 32'(illegal), 32'd0);
        checkOutput("t1_st_halt", 32'(state_out), 32'd5);
        checkOutput("t1_req_halt", 32'(mem_req), 32'd0);
        checkDbg("t1_instret", 4'd7, 32'd5);

        // Store/load with three wait cycles per access
        fillMem();
        mem[0]  = 32'h0050_0093;  // ADDI x1,x0,5
        mem[1]  = 32'h03C0_006F;  // JAL  x0,+60 -> 64
        mem[2]  = 32'h0;
        mem[3]  = 32'h0;
        mem[16] = 32'h0010_2423;  // SW x1,8(x0)
        mem[17] = 32'h0080_2303;  // LW x6,8(x0)
        mem[18] = 32'h0060_2623;  // SW x6,12(x0)
        mem[19] = 32'h0010_0073;  // EBREAK
        applyStimulus(3);
        releaseReset();
        pend = 1'b0;
        while (!halt && cyc < 400) begin
            runTo(cyc + 1);
            if (mem_req) begin
                if (pend) begin
                    checkOutput("t2_hold_addr", 32'(mem_addr), 32'(hold_addr));
                    checkOutput("t2_hold_we", 32'(mem_we), 32'(hold_we));
                    checkOutput("t2_hold_wdata", mem_wdata, hold_wdata);
                end
                if (mem_ack) pend = 1'b0;
                else if (!pend) begin
                    pend       = 1'b1;
                    hold_addr  = mem_addr;
                    hold_we    = mem_we;
                    hold_wdata = mem_wdata;
                end
            end else begin
                pend = 1'b0;
            end
        end
        checkOutput("t2_halt", 32'(halt), 32'd1);
        checkOutput("t2_cycles", 32'(cyc), 32'd49);
        checkOutput("t2_mem2", mem[2], 32'd5);
        checkOutput("t2_mem3_x6", mem[3], 32'd5);
        checkDbg("t2_mdr", 4'd5, 32'd5);
        checkDbg("t2_instret", 4'd7, 32'd5);
        checkOutput("t2_illegal", 32'(illegal), 32'd0);

        // Branches and JAL
        fillMem();
        mem[0]  = 32'h0000_0463;  // BEQ x0,x0,+8
        mem[2]  = 32'h0000_1463;  // BNE x0,x0,+8 (not taken)
        mem[3]  = 32'h0100_00EF;  // JAL x1,+16
        mem[7]  = 32'h0410_2023;  // SW x1,64(x0)
        mem[8]  = 32'h0010_0073;  // EBREAK
        mem[16] = 32'h0;
        applyStimulus(0);
        releaseReset();
        runTo(2);
        checkDbg("t3_beq_imm", 4'd6, 32'd8);
        runTo(3);
        checkDbg("t3_pc_beq", 4'd0, 32'd8);
        runTo(6);
        checkDbg("t3_pc_bne", 4'd0, 32'd12);
        runTo(8);
        checkDbg("t3_jal_imm", 4'd6, 32'd16);
        runTo(9);
        checkDbg("t3_pc_jal", 4'd0, 32'd28);
        checkDbg("t3_instret3", 4'd7, 32'd3);
        runToHalt(100);
        checkOutput("t3_cycles", 32'(cyc), 32'd15);
        checkOutput("t3_x1", mem[16], 32'd16);
        checkOutput("t3_illegal", 32'(illegal), 32'd0);

        // x0 hard-wired, registers beyond NREG=16 absent
        fillMem();
        mem[0]  = 32'h0090_0213;  // ADDI x4,x0,9
        mem[1]  = 32'h0070_0013;  // ADDI x0,x0,7
        mem[2]  = 32'h0010_0A13;  // ADDI x20,x0,1
        mem[3]  = 32'h0140_03B3;  // ADD  x7,x0,x20
        mem[4]  = 32'h0470_2023;  // SW x7,64(x0)
        mem[5]  = 32'h0440_2223;  // SW x4,68(x0)
        mem[6]  = 32'h0010_0073;  // EBREAK
        mem[16] = 32'hDEAD_BEEF;
        mem[17] = 32'hDEAD_BEEF;
        applyStimulus(0);
        releaseReset();
        runTo(12);
        checkOutput("t4_no_halt", 32'(halt), 32'd0);
        checkDbg("t4_instret3", 4'd7, 32'd3);
        runTo(14);
        checkDbg("t4_x0_read", 4'd2, 32'd0);
        checkDbg("t4_x20_read", 4'd3, 32'd0);
        runToHalt(100);
        checkOutput("t4_cycles", 32'(cyc), 32'd26);
        checkOutput("t4_x7", mem[16], 32'd0);
        checkOutput("t4_x4", mem[17], 32'd9);
        checkOutput("t4_illegal", 32'(illegal), 32'd0);
        checkDbg("t4_instret", 4'd7, 32'd6);

        // Reset in the middle of a stalled LW
        fillMem();
        mem[0] = 32'h0080_2303;   // LW x6,8(x0)
        mem[2] = 32'h1234_5678;
        applyStimulus(0);
        releaseReset();
        runTo(2);
        auto_ack = 1'b0;
        runTo(3);
        checkOutput("t5_st_mem", 32'(state_out), 32'd3);
        checkOutput("t5_mem_addr", 32'(mem_addr), 32'd2);
        runTo(5);
        checkOutput("t5_st_stall", 32'(state_out), 32'd3);
        rst = 1'b1;
        #1;
        checkOutput("t5_req_in_rst", 32'(mem_req), 32'd0);
        runTo(6);
        checkOutput("t5_st_rst", 32'(state_out), 32'd0);
        checkDbg("t5_pc_rst", 4'd0, 32'd0);
        force_ack = 1'b1;
        runTo(7);
        checkDbg("t5_late_ack_ir", 4'd1, 32'd0);
        checkOutput("t5_late_ack_req", 32'(mem_req), 32'd0);
        force_ack = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("t5_refetch_req", 32'(mem_req), 32'd1);
        checkOutput("t5_refetch_addr", 32'(mem_addr), 32'd0);
        checkOutput("t5_refetch_we", 32'(mem_we), 32'd0);
        auto_ack = 1'b1;
        runTo(8);
        checkDbg("t5_refetch_ir", 4'd1, 32'h0080_2303);
        checkDbg("t5_instret", 4'd7, 32'd0);

        // Illegal opcode halts and stays halted, ignoring stray acks
        fillMem();
        applyStimulus(0);
        releaseReset();
        runTo(2);
        force_ack = 1'b1;
        for (int k = 0; k < 12; k++) begin
            runTo(cyc + 1);
            checkOutput("t6_status", {26'b0, halt, illegal, mem_req, state_out}, 32'h0000_0035);
            checkDbg("t6_dbg9", 4'd9, 32'd3);
        end
        force_ack = 1'b0;
        checkDbg("t6_dbg8", 4'd8, 32'd5);
        checkDbg("t6_dbg12", 4'd12, 32'd0);
        checkDbg("t6_pc", 4'd0, 32'd0);
        checkDbg("t6_instret", 4'd7, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
